// File: rtl/music_sequencer_if.sv
//==============================================================================
// Module   : music_sequencer_if
// Brief    : Control, tone and note-divider bundle of the beat sequencer.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface music_sequencer_if #(
  parameter int N_CH   = 2,
  parameter int BEAT_W = 12,
  parameter int TONE_W = 32,
  parameter int DIV_W  = 22
);
  logic                     i_play;
  logic                     i_loop;
  logic                     i_restart;
  logic [N_CH*TONE_W-1:0]   i_tone_in;
  logic [BEAT_W-1:0]        o_ibeat;
  logic                     o_beat_tick;
  logic                     o_done;
  logic [N_CH*DIV_W-1:0]    o_note_div;
  logic                     o_div_valid;

  modport master (
    output i_play, i_loop, i_restart, i_tone_in,
    input  o_ibeat, o_beat_tick, o_done, o_note_div, o_div_valid
  );

  modport slave (
    input  i_play, i_loop, i_restart, i_tone_in,
    output o_ibeat, o_beat_tick, o_done, o_note_div, o_div_valid
  );
endinterface

`default_nettype wire

// File: rtl/music_sequencer.sv
//==============================================================================
// Module   : music_sequencer
// Brief    : Tempo/beat sequencer plus shared iterative tone-to-divider converter.
// Revision : 1.0
//==============================================================================
`default_nettype none

module music_sequencer #(
  parameter int N_CH      = 2,
  parameter int LEN       = 1535,
  parameter int BEAT_W    = 12,
  parameter int TEMPO_DIV = 4194304,
  parameter int NUM       = 50000000,
  parameter int TONE_W    = 32,
  parameter int DIV_W     = 22
) (
  input  logic              clk,
  input  logic              rst,
  music_sequencer_if.slave  bus
);

  localparam int CNT_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = $clog2(TONE_W + 1);

  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(TEMPO_DIV - 1);
  localparam logic [BEAT_W-1:0] c_LEN      = BEAT_W'(LEN);
  localparam logic [TONE_W-1:0] c_NUM      = TONE_W'(NUM);
  localparam logic [TONE_W-1:0] c_SAT      = TONE_W'((64'd1 << DIV_W) - 64'd1);
  localparam logic [BIT_W-1:0]  c_BIT_LAST = BIT_W'(TONE_W - 1);
  localparam logic [CH_W-1:0]   c_CH_LAST  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DIV   = 2'd2,
    S_STORE = 2'd3
  } state_t;

  logic [CNT_W-1:0]   r_cnt;
  logic [BEAT_W-1:0]  r_ibeat;
  logic               r_tick;
  logic               r_done;
  logic               r_pending;
  logic               w_run;
  logic               w_adv;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_pend_clr;
  logic               w_ch_clr;
  logic               w_ch_inc;
  logic               w_store;
  logic               w_publish;

  logic [CH_W-1:0]    r_ch;
  logic [TONE_W-1:0]  r_tone;
  logic [TONE_W-1:0]  r_quo;
  logic [TONE_W-1:0]  r_rem;
  logic [BIT_W-1:0]   r_bit;
  logic [DIV_W-1:0]   r_shadow [N_CH];
  logic [N_CH*DIV_W-1:0] r_note;
  logic               r_valid;

  logic [TONE_W-1:0]  w_tone_sel;
  logic [TONE_W:0]    w_shift;
  logic               w_ge;
  logic [DIV_W-1:0]   w_res;
  logic [N_CH*DIV_W-1:0] w_note_nx;

  // ---------------- tempo / beat index ----------------
  assign w_run = bus.i_play && !r_done && !bus.i_restart;
  assign w_adv = w_run && (r_cnt == c_CNT_LAST) && ((r_ibeat < c_LEN) || bus.i_loop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ibeat <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (bus.i_restart) begin
        r_cnt   <= '0;
        r_ibeat <= '0;
        r_done  <= 1'b0;
      end else if (w_run) begin
        if (r_cnt == c_CNT_LAST) begin
          r_cnt <= '0;
          if (r_ibeat < c_LEN) begin
            r_ibeat <= r_ibeat + 1'b1;
            r_tick  <= 1'b1;
          end else if (bus.i_loop) begin
            r_ibeat <= '0;
            r_tick  <= 1'b1;
          end else begin
            r_done <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // A new request wins over the converter consuming the previous one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b1;
    end else if (bus.i_restart || w_adv) begin
      r_pending <= 1'b1;
    end else if (w_pend_clr) begin
      r_pending <= 1'b0;
    end
  end

  // ---------------- converter FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pend_clr = 1'b0;
    w_ch_clr   = 1'b0;
    w_ch_inc   = 1'b0;
    w_store    = 1'b0;
    w_publish  = 1'b0;
    if (r_pending) begin
      w_state_nx = S_LOAD;
      w_pend_clr = 1'b1;
      w_ch_clr   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nx = S_IDLE;
        S_LOAD:  w_state_nx = S_DIV;
        S_DIV:   if (r_bit == c_BIT_LAST) w_state_nx = S_STORE;
        S_STORE: begin
          w_store = 1'b1;
          if (r_ch == c_CH_LAST) begin
            w_publish  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_ch_inc   = 1'b1;
            w_state_nx = S_LOAD;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // ---------------- restoring divider datapath ----------------
  assign w_tone_sel = bus.i_tone_in[int'(r_ch)*TONE_W +: TONE_W];
  assign w_shift    = {r_rem, r_quo[TONE_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_tone});
  assign w_res      = (r_tone == '0)  ? '0 :
                      (r_quo > c_SAT) ? c_SAT[DIV_W-1:0] : r_quo[DIV_W-1:0];

  // Last channel goes straight from the divider so note_div updates atomically
  for (genvar k = 0; k < N_CH; k++) begin : g_pack
    if (k == N_CH - 1) begin : g_last
      assign w_note_nx[k*DIV_W +: DIV_W] = w_res;
    end else begin : g_shadow
      assign w_note_nx[k*DIV_W +: DIV_W] = r_shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch    <= '0;
      r_tone  <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_bit   <= '0;
      r_note  <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < N_CH; k++) r_shadow[k] <= '0;
    end else begin
      r_valid <= w_publish;
      if (w_ch_clr) begin
        r_ch <= '0;
      end else if (w_ch_inc) begin
        r_ch <= r_ch + 1'b1;
      end
      if (r_state == S_LOAD) begin
        r_tone <= w_tone_sel;
        r_quo  <= c_NUM;
        r_rem  <= '0;
        r_bit  <= '0;
      end else if (r_state == S_DIV) begin
        r_rem <= w_ge ? (w_shift[TONE_W-1:0] - r_tone) : w_shift[TONE_W-1:0];
        r_quo <= {r_quo[TONE_W-2:0], w_ge};
        r_bit <= r_bit + 1'b1;
      end
      if (w_store) r_shadow[r_ch] <= w_res;
      if (w_publish) r_note <= w_note_nx;
    end
  end

  assign bus.o_ibeat     = r_ibeat;
  assign bus.o_beat_tick = r_tick;
  assign bus.o_done      = r_done;
  assign bus.o_note_div  = r_note;
  assign bus.o_div_valid = r_valid;

endmodule

`default_nettype wire
